// File: rtl/id_ctrl_stage_if.sv
// ---------------------------------------------------------------------------
// id_ctrl_if : ID-stage decode bus between the instruction source and the
//              registered decode stage (id_ctrl_stage).
//
// Source side (master drives): in_valid, mode, op_code, s_in, cond, status,
//                              freeze, flush
// Stage side  (slave drives) : out_valid, exe_cmd, mem_read, mem_write,
//                              wb_en, b, s_out, busy
// ---------------------------------------------------------------------------
interface id_ctrl_if #(
    parameter int EXE_CMD_W = 4
) ();
    logic                 in_valid;
    logic [1:0]           mode;
    logic [3:0]           op_code;
    logic                 s_in;
    logic [3:0]           cond;
    logic [3:0]           status;
    logic                 freeze;
    logic                 flush;

    logic                 out_valid;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 mem_read;
    logic                 mem_write;
    logic                 wb_en;
    logic                 b;
    logic                 s_out;
    logic                 busy;

    modport master (
        output in_valid, mode, op_code, s_in, cond, status, freeze, flush,
        input  out_valid, exe_cmd, mem_read, mem_write, wb_en, b, s_out, busy
    );

    modport slave (
        input  in_valid, mode, op_code, s_in, cond, status, freeze, flush,
        output out_valid, exe_cmd, mem_read, mem_write, wb_en, b, s_out, busy
    );
endinterface

// File: rtl/id_ctrl_stage.sv
// ---------------------------------------------------------------------------
// id_ctrl_stage : registered, condition-aware ID decode stage.
//   Decodes mode/op_code/S into the execute command and the memory,
//   writeback and branch controls, evaluates cond against NZCV and registers
//   the result into the ID/EX boundary. After an issued branch the next
//   BR_SHADOW valid instructions are squashed. flush beats freeze.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - id_ctrl_if.slave (instruction in, registered controls out, busy)
// ---------------------------------------------------------------------------
module id_ctrl_stage #(
    parameter int EXE_CMD_W = 4,
    parameter bit COND_EN   = 1'b1,
    parameter int BR_SHADOW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    id_ctrl_if.slave   bus
);

    localparam logic [2:0] SHADOW_LD = 3'(BR_SHADOW);

    // ARM condition evaluation, status = {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] st);
        logic n, z, cf, v, r;
        n  = st[3];
        z  = st[2];
        cf = st[1];
        v  = st[0];
        case (c)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = cf;
            4'b0011: r = ~cf;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = cf & ~z;
            4'b1001: r = ~cf | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic                 dec_vld_s, dec_mr_s, dec_mw_s, dec_wb_s, dec_b_s, dec_s_s;
    logic [3:0]           dec_cmd_s;
    logic                 pass_s, issue_s;

    logic                 out_valid_d, out_valid_q;
    logic [EXE_CMD_W-1:0] exe_cmd_d, exe_cmd_q;
    logic                 mem_read_d, mem_read_q;
    logic                 mem_write_d, mem_write_q;
    logic                 wb_en_d, wb_en_q;
    logic                 b_d, b_q;
    logic                 s_out_d, s_out_q;
    logic [2:0]           cnt_d, cnt_q;

    // Instruction decode; dec_vld_s=0 marks a NOP (all controls zero)
    always_comb begin
        dec_vld_s = 1'b0;
        dec_cmd_s = 4'b0000;
        dec_mr_s  = 1'b0;
        dec_mw_s  = 1'b0;
        dec_wb_s  = 1'b0;
        dec_b_s   = 1'b0;
        dec_s_s   = 1'b0;
        case (bus.mode)
            2'b00: begin
                dec_vld_s = 1'b1;
                dec_wb_s  = 1'b1;
                dec_s_s   = bus.s_in;
                case (bus.op_code)
                    4'b1101: dec_cmd_s = 4'b0001;
                    4'b1111: dec_cmd_s = 4'b1001;
                    4'b0100: dec_cmd_s = 4'b0010;
                    4'b0101: dec_cmd_s = 4'b0011;
                    4'b0010: dec_cmd_s = 4'b0100;
                    4'b0110: dec_cmd_s = 4'b0101;
                    4'b0000: dec_cmd_s = 4'b0110;
                    4'b1100: dec_cmd_s = 4'b0111;
                    4'b0001: dec_cmd_s = 4'b1000;
                    // compare/test only update flags
                    4'b1010: begin dec_cmd_s = 4'b0100; dec_wb_s = 1'b0; dec_s_s = 1'b1; end
                    4'b1000: begin dec_cmd_s = 4'b0110; dec_wb_s = 1'b0; dec_s_s = 1'b1; end
                    default: begin dec_vld_s = 1'b0; dec_wb_s = 1'b0; dec_s_s = 1'b0; end
                endcase
            end
            2'b01: begin
                if (bus.op_code == 4'b0100) begin
                    dec_vld_s = 1'b1;
                    dec_cmd_s = 4'b0010;
                    if (bus.s_in) begin
                        dec_mr_s = 1'b1;
                        dec_wb_s = 1'b1;
                    end else begin
                        dec_mw_s = 1'b1;
                    end
                end else begin
                    dec_vld_s = 1'b0;
                end
            end
            2'b10: begin
                dec_vld_s = 1'b1;
                dec_b_s   = 1'b1;
            end
            default: dec_vld_s = 1'b0;
        endcase
    end

    // Condition check and issue decision
    always_comb begin
        if (COND_EN) begin
            pass_s = cond_pass(bus.cond, bus.status);
        end else begin
            pass_s = 1'b1;
        end
        issue_s = bus.in_valid & pass_s & (cnt_q == 3'd0);
    end

    // Next state for the ID/EX register and the branch-shadow counter
    always_comb begin
        out_valid_d = out_valid_q;
        exe_cmd_d   = exe_cmd_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        wb_en_d     = wb_en_q;
        b_d         = b_q;
        s_out_d     = s_out_q;
        cnt_d       = cnt_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            exe_cmd_d   = {EXE_CMD_W{1'b0}};
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            wb_en_d     = 1'b0;
            b_d         = 1'b0;
            s_out_d     = 1'b0;
            cnt_d       = 3'd0;
        end else if (bus.freeze) begin
            cnt_d = cnt_q;
        end else if (issue_s) begin
            out_valid_d = dec_vld_s;
            exe_cmd_d   = EXE_CMD_W'(dec_cmd_s);
            mem_read_d  = dec_mr_s;
            mem_write_d = dec_mw_s;
            wb_en_d     = dec_wb_s;
            b_d         = dec_b_s;
            s_out_d     = dec_s_s;
            // issue implies cnt_q==0, so only a branch changes the counter
            if (dec_b_s) begin
                cnt_d = SHADOW_LD;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            out_valid_d = 1'b0;
            exe_cmd_d   = {EXE_CMD_W{1'b0}};
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            wb_en_d     = 1'b0;
            b_d         = 1'b0;
            s_out_d     = 1'b0;
            // only real (valid) shadow instructions use up the shadow
            if (bus.in_valid && (cnt_q != 3'd0)) begin
                cnt_d = cnt_q - 3'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // ID/EX pipeline register and shadow counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            exe_cmd_q   <= {EXE_CMD_W{1'b0}};
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_en_q     <= 1'b0;
            b_q         <= 1'b0;
            s_out_q     <= 1'b0;
            cnt_q       <= 3'd0;
        end else begin
            out_valid_q <= out_valid_d;
            exe_cmd_q   <= exe_cmd_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            wb_en_q     <= wb_en_d;
            b_q         <= b_d;
            s_out_q     <= s_out_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.exe_cmd   = exe_cmd_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.b         = b_q;
    assign bus.s_out     = s_out_q;
    assign bus.busy      = (cnt_q != 3'd0);

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered, condition-aware decode stage for the ARM-style pipeline: it decodes mode/opcode/S into execute command and memory/writeback/branch controls, evaluates the 4-bit condition field against the NZCV status, and registers the result into the ID/EX boundary. It supports freeze (hazard stall) and flush, and suppresses a parametrised number of branch-shadow instructions after a taken branch. It replaces the purely combinational control decode at the ID stage.

## Interface

Parameters:
- EXE_CMD_W, 4, width of exe_cmd (≥4); decoded 4-bit command is zero-extended.
- COND_EN, 1, 1 = evaluate cond; 0 = treat every instruction as AL.
- BR_SHADOW, 2, number of accepted instructions squashed after an issued branch (0..7).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present at ID.
- mode  in  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 reserved.
- op_code  in  4  data-proc opcode.
- s_in  in  1  S bit (data-proc) / L bit (memory: 1 = load).
- cond  in  4  ARM condition field.
- status  in  4  {N,Z,C,V} = status[3:0].
- freeze  in  1  hold all registers.
- flush  in  1  squash stage contents.
- out_valid  out  1  registered: valid instruction in EX.
- exe_cmd  out  EXE_CMD_W  registered ALU command.
- mem_read, mem_write, wb_en, b, s_out  out  1 each  registered controls.
- busy  out  1  shadow counter non-zero (combinational from counter).

## Operation

- Decode, mode 00 (wb_en=1, s_out=s_in unless noted): MOV 1101→0001; MVN 1111→1001; ADD 0100→0010; ADC 0101→0011; SUB 0010→0100; SBC 0110→0101; AND 0000→0110; ORR 1100→0111; EOR 0001→1000; CMP 1010→0100 with wb_en=0, s_out=1; TST 1000→0110 with wb_en=0, s_out=1; any other opcode → NOP.
- Mode 01, op_code 0100: s_in=1 → LDR: mem_read=1, wb_en=1, exe_cmd=0010, s_out=0; s_in=0 → STR: mem_write=1, exe_cmd=0010, s_out=0. Other opcodes → NOP.
- Mode 10: b=1, all else 0. Mode 11: NOP.
- NOP/bubble = out_valid=0 and all controls 0.
- Condition pass: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
- Issue = in_valid & pass & shadow counter==0. Issue loads decoded controls with out_valid=1; otherwise a bubble is loaded.
- Shadow counter (3 bits): issuing a branch (b=1) loads BR_SHADOW. While counter>0, each cycle with in_valid=1 loads a bubble and decrements by 1. Cycles with in_valid=0 neither issue nor decrement. Failed-condition branches do not load the counter.
- Priority: flush > freeze > normal.
  - flush: bubble loaded, counter cleared, even if freeze=1.
  - freeze: output register and counter hold.

## Timing

- Reset (async, rst_n=0): out_valid, exe_cmd, mem_read, mem_write, wb_en, b, s_out = 0; counter = 0; busy = 0. Release is synchronous to the next clk edge.
- Latency: 1 cycle, inputs at edge k → outputs valid after edge k.
- busy asserts the cycle after the branch issues and deasserts after the BR_SHADOW-th squashed instruction.
- Branch issued while counter>0: impossible, because the branch is squashed.
- BR_SHADOW=0: no squashing, busy never asserts.
- Reset mid-shadow: counter cleared immediately and asynchronously.

## Test plan

- Reset: hold rst_n=0 with in_valid=1 ADD → all outputs 0. Release rst_n → next edge, ADD gives exe_cmd=0010, wb_en=1, out_valid=1.
- Decode sweep, cond=1110: all 11 data-proc opcodes plus LDR (mode 01, s_in=1) and STR (s_in=0) → table values. LDR: mem_read=1, wb_en=1. STR: mem_write=1, wb_en=0. Opcode 0011 → bubble.
- Condition: status=0100 (Z=1). EQ ADD → issues. NE ADD → bubble. cond=1111 → bubble. With COND_EN=0, NE ADD → issues.
- Branch shadow, BR_SHADOW=2: taken B, then three ADDs → B issues, first two ADDs are bubbles with busy=1, third ADD issues with busy=0.
- Freeze/flush: freeze=1 for 3 cycles with SUB held → outputs stay SUB and counter unchanged. flush=1 together with freeze=1 → bubble next cycle.
- Flush mid-shadow: B issued, then flush on the next cycle → counter=0, and the next ADD issues immediately.
